// File: rtl/calc_key_sequencer.sv
// calc_key_sequencer: keypad front end for the calculator ALU; accumulates operands, issues the opcode, captures the result.
// Optional divide-by-zero trap enabled by defining CALC_DIV0_CHECK_EN.
module calc_key_sequencer #(
  parameter int MAX_DIGITS = 9,
  parameter int ALU_LAT    = 2
) (
  input  logic        _clock,
  input  logic        _reset_n,
  input  logic        _key_valid,
  input  logic [3:0]  _key_code,
  input  logic [31:0] _alu_result,
  output logic [31:0] _op1,
  output logic [31:0] _op2,
  output logic [3:0]  _opcao,
  output logic [31:0] _display,
  output logic        _busy,
  output logic        _result_valid,
  output logic        _err
);
  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int LW = ALU_LAT > 2 ? $clog2(ALU_LAT) : 1;
  typedef enum logic [2:0] {S_OP1, S_OPR, S_OP2, S_EXEC, S_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lat, lat_n;
  logic [3:0] pend, pend_n, opcao_n, hot;
  logic [31:0] op1_n, op2_n, disp_n, dz;
  logic rv_n, is_dig, is_op, is_eq, is_clr, full;
  assign is_dig = _key_valid && _key_code < 4'd10;
  assign is_op  = _key_valid && _key_code >= 4'd10 && _key_code <= 4'd13;
  assign is_eq  = _key_valid && _key_code == 4'd14;
  assign is_clr = _key_valid && _key_code == 4'd15;
  assign hot    = 4'b1000 >> (_key_code - 4'd10);
  assign dz     = {28'd0, _key_code};
  assign full   = cnt >= CW'(MAX_DIGITS);
  assign _busy  = state == S_EXEC;
`ifdef CALC_DIV0_CHECK_EN
  logic err_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lat_n   = lat;
    pend_n  = pend;
    op1_n   = _op1;
    op2_n   = _op2;
    opcao_n = _opcao;
    disp_n  = _display;
    rv_n    = 1'b0;
`ifdef CALC_DIV0_CHECK_EN
    err_n   = _err;
    if (is_dig && state != S_EXEC) err_n = 1'b0;
`endif
    if (is_clr) begin
      state_n = S_OP1;
      cnt_n   = '0;
      lat_n   = '0;
      pend_n  = '0;
      op1_n   = '0;
      op2_n   = '0;
      opcao_n = '0;
      disp_n  = '0;
`ifdef CALC_DIV0_CHECK_EN
      err_n   = 1'b0;
`endif
    end else begin
      case (state)
        S_OP1:
          if (is_dig) begin
            if (!full) begin
              op1_n  = _op1 * 32'd10 + dz;
              disp_n = op1_n;
              cnt_n  = cnt + 1'b1;
            end
          end else if (is_op) begin
            pend_n  = hot;
            state_n = S_OPR;
          end
        S_OPR:
          if (is_op) pend_n = hot;
          else if (is_dig) begin
            op2_n   = dz;
            disp_n  = dz;
            cnt_n   = CW'(1);
            state_n = S_OP2;
          end
        S_OP2:
          if (is_dig) begin
            if (!full) begin
              op2_n  = _op2 * 32'd10 + dz;
              disp_n = op2_n;
              cnt_n  = cnt + 1'b1;
            end
          end else if (is_eq) begin
`ifdef CALC_DIV0_CHECK_EN
            if (pend == 4'b0001 && _op2 == '0) begin
              err_n   = 1'b1;
              disp_n  = '0;
              op1_n   = '0;
              state_n = S_DONE;
            end else
`endif
            begin
              opcao_n = pend;
              lat_n   = '0;
              state_n = S_EXEC;
            end
          end
        S_EXEC:
          if (lat == LW'(ALU_LAT - 1)) begin
            op1_n   = _alu_result;
            disp_n  = _alu_result;
            rv_n    = 1'b1;
            opcao_n = '0;
            state_n = S_DONE;
          end else lat_n = lat + 1'b1;
        S_DONE:
          if (is_dig) begin
            op1_n   = dz;
            op2_n   = '0;
            disp_n  = dz;
            cnt_n   = CW'(1);
            state_n = S_OP1;
          end else if (is_op) begin
            pend_n  = hot;
            state_n = S_OPR;
          end
        default: state_n = S_OP1;
      endcase
    end
  end
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state         <= S_OP1;
      cnt           <= '0;
      lat           <= '0;
      pend          <= '0;
      _op1          <= '0;
      _op2          <= '0;
      _opcao        <= '0;
      _display      <= '0;
      _result_valid <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      lat           <= lat_n;
      pend          <= pend_n;
      _op1          <= op1_n;
      _op2          <= op2_n;
      _opcao        <= opcao_n;
      _display      <= disp_n;
      _result_valid <= rv_n;
    end
  end
`ifdef CALC_DIV0_CHECK_EN
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) _err <= 1'b0;
    else _err <= err_n;
  end
`else
  assign _err = 1'b0;
`endif
endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb_calc_key_sequencer: randomized key stream checked every cycle against a keystroke-level calculator model.
module tb_calc_key_sequencer;
  localparam int MAXD = 9;
  localparam int LAT  = 2;
  localparam int ENTRY1 = 0, CHOSE = 1, ENTRY2 = 2, RUNNING = 3, SHOWN = 4;
  logic clk = 0, rst_n = 0, kv = 0;
  logic [3:0] kc = 0;
  logic [31:0] alu_r = 0, op1, op2, disp;
  logic [3:0] opc;
  logic busy, rv, err;
  int nvec = 0, nerr = 0;

  calc_key_sequencer #(.MAX_DIGITS(MAXD), .ALU_LAT(LAT)) dut (
    ._clock(clk), ._reset_n(rst_n), ._key_valid(kv), ._key_code(kc), ._alu_result(alu_r),
    ._op1(op1), ._op2(op2), ._opcao(opc), ._display(disp), ._busy(busy),
    ._result_valid(rv), ._err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
    case (o)
      4'b1000: return a + b;
      4'b0100: return a - b;
      4'b0010: return a * b;
      4'b0001: return b == 0 ? 32'hFFFF_FFFF : a / b;
      default: return 32'd0;
    endcase
  endfunction

  // one-stage registered ALU: with the extra capture edge this gives two edges of latency
  always @(posedge clk) if (opc != 0) alu_r <= alu(op1, op2, opc);

  int phase, left;
  byte unsigned q[$];
  logic [31:0] e_op1, e_op2, e_disp, e_res;
  logic [3:0] e_opc, e_pend;
  logic e_rv, e_err;

  function automatic logic [31:0] qval();
    longint v = 0;
    int n = q.size();
    for (int i = 0; i < n; i++) v += longint'(q[i]) * longint'(10 ** (n - 1 - i));
    return v[31:0];
  endfunction

  function automatic logic [3:0] onehot(input logic [3:0] k);
    case (k)
      4'd10: return 4'b1000;
      4'd11: return 4'b0100;
      4'd12: return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic m_reset();
    phase = ENTRY1; left = 0; q.delete();
    e_op1 = 0; e_op2 = 0; e_disp = 0; e_res = 0; e_opc = 0; e_pend = 0; e_rv = 0; e_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else begin
      e_rv = 0;
      if (kv && kc == 15) m_reset();
      else if (phase == RUNNING) begin
        left--;
        if (left == 0) begin
          e_op1 = e_res; e_disp = e_res; e_rv = 1; e_opc = 0; phase = SHOWN;
        end
      end else if (kv && kc < 10) begin
`ifdef CALC_DIV0_CHECK_EN
        e_err = 0;
`endif
        if (phase == ENTRY1 || phase == ENTRY2) begin
          if (q.size() < MAXD) begin
            q.push_back(byte'(kc));
            if (phase == ENTRY1) e_op1 = qval(); else e_op2 = qval();
            e_disp = qval();
          end
        end else begin
          q.delete(); q.push_back(byte'(kc));
          e_disp = {28'd0, kc};
          if (phase == CHOSE) begin e_op2 = e_disp; phase = ENTRY2; end
          else begin e_op1 = e_disp; e_op2 = 0; phase = ENTRY1; end
        end
      end else if (kv && kc < 14) begin
        if (phase != ENTRY2) begin e_pend = onehot(kc); phase = CHOSE; end
      end else if (kv && phase == ENTRY2) begin
`ifdef CALC_DIV0_CHECK_EN
        if (e_pend == 4'b0001 && e_op2 == 0) begin
          e_err = 1; e_disp = 0; e_op1 = 0; phase = SHOWN;
        end else
`endif
        begin
          e_res = alu(e_op1, e_op2, e_pend); e_opc = e_pend; left = LAT; phase = RUNNING;
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("op1", op1, e_op1);
    chk("op2", op2, e_op2);
    chk("opcao", {28'd0, opc}, {28'd0, e_opc});
    chk("display", disp, e_disp);
    chk("busy", {31'd0, busy}, {31'd0, phase == RUNNING});
    chk("result_valid", {31'd0, rv}, {31'd0, e_rv});
    chk("err", {31'd0, err}, {31'd0, e_err});
  end

  task automatic press(input logic [3:0] k);
    kv = 1; kc = k;
    @(negedge clk);
    kv = 0;
  endtask

  task automatic wait_rv(output bit ok, output int oc);
    ok = 0; oc = 0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (rv) ok = 1;
      else begin
        if (opc != 0) oc++;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int oc;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_display", disp, 0);
    chk("rst_op1", op1, 0);
    chk("rst_opcao", {28'd0, opc}, 0);

    press(1); press(2); press(10); press(3); press(0); press(14);
    chk("add_opcao", {28'd0, opc}, 32'b1000);
    chk("add_busy", {31'd0, busy}, 1);
    wait_rv(ok, oc);
    chk("add_rv_seen", {31'd0, ok}, 1);
    chk("add_exec_cycles", oc, LAT);
    chk("add_result", disp, 42);
    chk("add_busy_fall", {31'd0, busy}, 0);
    @(negedge clk);
    chk("add_rv_once", {31'd0, rv}, 0);

    press(12); press(2); press(14);
    chk("chain_op1", op1, 42);
    chk("chain_op2", op2, 2);
    chk("chain_opcao", {28'd0, opc}, 32'b0010);
    wait_rv(ok, oc);
    chk("chain_rv_seen", {31'd0, ok}, 1);
    chk("chain_result", disp, 84);

    press(15);
    repeat (10) press(9);
    chk("maxdig_op1", op1, 999999999);
    chk("maxdig_display", disp, 999999999);

    press(15); press(7); press(11); press(10); press(5); press(14);
    chk("replace_opcao", {28'd0, opc}, 32'b1000);
    wait_rv(ok, oc);
    chk("replace_result", disp, 12);

    press(15); press(5); press(14);
    for (int i = 0; i < 3; i++) begin
      chk("eq_op1_opcao", {28'd0, opc}, 0);
      chk("eq_op1_busy", {31'd0, busy}, 0);
      @(negedge clk);
    end

    press(15); press(1); press(10); press(2); press(14); press(15);
    chk("clr_exec_op1", op1, 0);
    chk("clr_exec_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 4; i++) begin
      chk("clr_exec_no_rv", {31'd0, rv}, 0);
      @(negedge clk);
    end

    press(3); press(4);
    chk("entry_34", disp, 34);
    #2 rst_n = 0;
    #1;
    chk("async_op1", op1, 0);
    chk("async_display", disp, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

`ifdef CALC_DIV0_CHECK_EN
    press(8); press(13); press(0); press(14);
    chk("div0_err", {31'd0, err}, 1);
    chk("div0_display", disp, 0);
    for (int i = 0; i < 3; i++) begin
      chk("div0_opcao", {28'd0, opc}, 0);
      @(negedge clk);
    end
    press(3);
    chk("div0_err_clear", {31'd0, err}, 0);
    chk("div0_new_digit", disp, 3);
`else
    press(8); press(13); press(0); press(14);
    chk("div0_opcao", {28'd0, opc}, 32'b0001);
    wait_rv(ok, oc);
    chk("div0_rv_seen", {31'd0, ok}, 1);
    chk("div0_raw_result", disp, 32'hFFFF_FFFF);
    chk("div0_err_tied", {31'd0, err}, 0);
`endif

    press(15);
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      kv = $urandom_range(0, 3) != 0;
      kc = r < 55 ? 4'($urandom_range(0, 9)) : r < 78 ? 4'($urandom_range(10, 13)) : r < 98 ? 4'd14 : 4'd15;
      @(negedge clk);
    end
    kv = 0;
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
